// File: rtl/ro_edge_counter.sv
// ro_edge_counter: counts synchronized OSC rising edges over a WIN_CYCLES-long window of CLK cycles.
// Define RO_EDGE_COUNTER_SAT_EN to make the count saturate and report it on OVF; otherwise it wraps and OVF is 0.
module ro_edge_counter #(
  parameter int CNT_W = 24,
  parameter int WIN_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN_CYCLES,
  input  logic             OSC,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] COUNT,
  output logic             OVF
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] acc_q, acc_d, acc_inc, count_q, count_d;
  logic             s1_q, s2_q, edge_q, pulse, done_q, done_d;
  logic             sat_q, sat_d, sat_inc, ovf_q, ovf_d;
  assign pulse = s2_q & ~edge_q;
`ifdef RO_EDGE_COUNTER_SAT_EN
  assign acc_inc = (pulse && !(&acc_q)) ? acc_q + 1'b1 : acc_q;
  assign sat_inc = sat_q | (pulse & (&acc_q));
  assign OVF     = ovf_q;
`else
  assign acc_inc = acc_q + CNT_W'(pulse);
  assign sat_inc = 1'b0;
  assign OVF     = 1'b0;
`endif
  assign BUSY  = state_q == S_COUNT;
  assign DONE  = done_q;
  assign COUNT = count_q;
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (START) begin
        win_d   = WIN_CYCLES;
        acc_d   = '0;
        sat_d   = 1'b0;
        state_d = (WIN_CYCLES == '0) ? S_FINISH : S_COUNT;
        done_d  = WIN_CYCLES == '0;
        count_d = (WIN_CYCLES == '0) ? '0 : count_q;
        ovf_d   = (WIN_CYCLES == '0) ? 1'b0 : ovf_q;
      end
      S_COUNT: begin
        acc_d = acc_inc;
        sat_d = sat_inc;
        win_d = win_q - 1'b1;
        // last window cycle: publish including this cycle's pulse so DONE lands in FINISH
        if (win_q == WIN_W'(1)) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          count_d = acc_inc;
          ovf_d   = sat_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      s1_q    <= OSC;
      s2_q    <= s1_q;
      edge_q  <= s2_q;
    end
  end
endmodule
